// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core's iBus/dBus, the arbiter and the shared memory port.
// slave = arbiter view, master = core + memory view.
interface riscv_mem_arbiter_if;
  logic        iBus_cmd_valid;
  logic        iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_rsp_ready;
  logic        iBus_rsp_err;
  logic [31:0] iBus_rsp_inst;

  logic        dBus_cmd_valid;
  logic        dBus_cmd_ready;
  logic [31:0] dBus_cmd_payload_address;
  logic [31:0] dBus_cmd_payload_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        dBus_cmd_payload_wr;
  logic        dBus_rsp_ready;
  logic        dBus_rsp_err;
  logic [31:0] dBus_rsp_data;

  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [31:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [1:0]  mem_cmd_size;
  logic        mem_cmd_wr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  modport slave (
    input  iBus_cmd_valid, iBus_cmd_payload_pc,
    output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst,
    input  dBus_cmd_valid, dBus_cmd_payload_address, dBus_cmd_payload_data,
    input  dBus_cmd_payload_size, dBus_cmd_payload_wr,
    output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_err, dBus_rsp_data,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_wdata, mem_cmd_size, mem_cmd_wr,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport master (
    output iBus_cmd_valid, iBus_cmd_payload_pc,
    input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst,
    output dBus_cmd_valid, dBus_cmd_payload_address, dBus_cmd_payload_data,
    output dBus_cmd_payload_size, dBus_cmd_payload_wr,
    input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_err, dBus_rsp_data,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_wdata, mem_cmd_size, mem_cmd_wr,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between iBus and dBus: locked arbitration on the command
// side, in-order source-ID FIFO to steer responses back to the issuing requester.
module riscv_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          DBUS_PRIORITY   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  riscv_mem_arbiter_if.slave        bus,
  output logic                      rsp_orphan
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t                    state;
  logic                      last_grant;   // 0 = iBus, 1 = dBus
  logic [MAX_OUTSTANDING-1:0] id_mem;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;

  logic owner_d;
  logic owner_valid;
  logic fifo_full;
  logic fifo_empty;
  logic present;
  logic accept;
  logic head_id;
  logic rsp_pop;
  logic orphan_hit;

  // Owner selection: locked owner in HOLD_x, otherwise arbitrate among valid requesters.
  always_comb begin
    owner_d     = 1'b0;
    owner_valid = 1'b0;
    unique case (state)
      HOLD_I: begin
        owner_d     = 1'b0;
        owner_valid = bus.iBus_cmd_valid;
      end
      HOLD_D: begin
        owner_d     = 1'b1;
        owner_valid = bus.dBus_cmd_valid;
      end
      default: begin
        owner_valid = bus.iBus_cmd_valid | bus.dBus_cmd_valid;
        if (bus.iBus_cmd_valid && bus.dBus_cmd_valid)
          owner_d = DBUS_PRIORITY ? 1'b1 : ~last_grant;
        else
          owner_d = bus.dBus_cmd_valid;
      end
    endcase
  end

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == CNT_W'(0));
  assign present    = owner_valid & ~fifo_full & ~rst;
  assign accept     = present & bus.mem_cmd_ready;

  // Command mux toward memory; iBus fetches are always word reads.
  always_comb begin
    bus.mem_cmd_valid  = 1'b0;
    bus.mem_cmd_addr   = 32'd0;
    bus.mem_cmd_wdata  = 32'd0;
    bus.mem_cmd_size   = 2'd0;
    bus.mem_cmd_wr     = 1'b0;
    bus.iBus_cmd_ready = 1'b0;
    bus.dBus_cmd_ready = 1'b0;
    if (present) begin
      bus.mem_cmd_valid = 1'b1;
      if (owner_d) begin
        bus.mem_cmd_addr  = bus.dBus_cmd_payload_address;
        bus.mem_cmd_wdata = bus.dBus_cmd_payload_data;
        bus.mem_cmd_size  = bus.dBus_cmd_payload_size;
        bus.mem_cmd_wr    = bus.dBus_cmd_payload_wr;
      end else begin
        bus.mem_cmd_addr  = bus.iBus_cmd_payload_pc;
        bus.mem_cmd_size  = 2'd2;
      end
      bus.iBus_cmd_ready = bus.mem_cmd_ready & ~owner_d;
      bus.dBus_cmd_ready = bus.mem_cmd_ready &  owner_d;
    end
  end

  assign head_id    = id_mem[rd_ptr];
  assign rsp_pop    = bus.mem_rsp_valid & ~fifo_empty & ~rst;
  assign orphan_hit = bus.mem_rsp_valid & fifo_empty;

  // Response steering from the FIFO head; idle data lanes are held at zero.
  always_comb begin
    bus.iBus_rsp_ready = 1'b0;
    bus.iBus_rsp_err   = 1'b0;
    bus.iBus_rsp_inst  = 32'd0;
    bus.dBus_rsp_ready = 1'b0;
    bus.dBus_rsp_err   = 1'b0;
    bus.dBus_rsp_data  = 32'd0;
    if (rsp_pop) begin
      if (head_id) begin
        bus.dBus_rsp_ready = 1'b1;
        bus.dBus_rsp_err   = bus.mem_rsp_err;
        bus.dBus_rsp_data  = bus.mem_rsp_rdata;
      end else begin
        bus.iBus_rsp_ready = 1'b1;
        bus.iBus_rsp_err   = bus.mem_rsp_err;
        bus.iBus_rsp_inst  = bus.mem_rsp_rdata;
      end
    end
  end

  // In-order ID FIFO; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        id_mem[wr_ptr] <= owner_d;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (rsp_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({accept, rsp_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Lock FSM: a presented-but-unaccepted command pins the owner until memory takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= IDLE;
      last_grant <= owner_d;
    end else if (state == IDLE && present) begin
      state      <= owner_d ? HOLD_D : HOLD_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rsp_orphan <= 1'b0;
    else if (orphan_hit)
      rsp_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus a randomized
// phase, all compared against a queue-based model of the arbitration rules.
module tb_riscv_mem_arbiter;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic orphan, orphan1;

  riscv_mem_arbiter_if bus ();
  riscv_mem_arbiter_if bus1 ();

  riscv_mem_arbiter #(.MAX_OUTSTANDING(DEPTH), .DBUS_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rsp_orphan(orphan));
  riscv_mem_arbiter #(.MAX_OUTSTANDING(DEPTH), .DBUS_PRIORITY(1'b1)) dut_prio (
    .clk(clk), .rst(rst), .bus(bus1), .rsp_orphan(orphan1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: lock owner (-1 none, 0 I, 1 D), last grant, queue of source IDs.
  int lock_m, last_m;
  bit orphan_m;
  bit idq[$];

  int          snap_grant;
  logic        snap_irsp, snap_drsp, snap_derr, snap_mvalid, snap_wr, snap_orphan;
  logic [31:0] snap_addr, snap_inst, snap_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lock_m = -1;
    last_m = 1;
    orphan_m = 1'b0;
    idq.delete();
  endtask

  task automatic idle_inputs();
    bus.iBus_cmd_valid = 0; bus.iBus_cmd_payload_pc = 0;
    bus.dBus_cmd_valid = 0; bus.dBus_cmd_payload_address = 0; bus.dBus_cmd_payload_data = 0;
    bus.dBus_cmd_payload_size = 0; bus.dBus_cmd_payload_wr = 0;
    bus.mem_cmd_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0; bus.mem_rsp_err = 0;
    bus1.iBus_cmd_valid = 0; bus1.iBus_cmd_payload_pc = 0;
    bus1.dBus_cmd_valid = 0; bus1.dBus_cmd_payload_address = 0; bus1.dBus_cmd_payload_data = 0;
    bus1.dBus_cmd_payload_size = 0; bus1.dBus_cmd_payload_wr = 0;
    bus1.mem_cmd_ready = 0; bus1.mem_rsp_valid = 0; bus1.mem_rsp_rdata = 0; bus1.mem_rsp_err = 0;
  endtask

  // One clock cycle: inputs already set after a falling edge; check, then advance model.
  task automatic step();
    int          own;
    bit          ov, present, acc, hit, head, orph, r;
    logic [31:0] e_addr, e_wdata, e_size;
    bit          e_wr, e_i, e_d;
    #1;
    r = rst;
    if (lock_m >= 0) begin
      own = lock_m;
      ov  = (own == 1) ? bus.dBus_cmd_valid : bus.iBus_cmd_valid;
    end else if (bus.iBus_cmd_valid && bus.dBus_cmd_valid) begin
      own = 1 - last_m;
      ov  = 1'b1;
    end else begin
      own = bus.dBus_cmd_valid ? 1 : 0;
      ov  = bus.iBus_cmd_valid || bus.dBus_cmd_valid;
    end
    present = ov && (idq.size() < DEPTH) && !r;
    acc     = present && bus.mem_cmd_ready;
    hit     = !r && bus.mem_rsp_valid && (idq.size() > 0);
    orph    = !r && bus.mem_rsp_valid && (idq.size() == 0);
    head    = (idq.size() > 0) ? idq[0] : 1'b0;
    e_addr = 0; e_wdata = 0; e_size = 0; e_wr = 0;
    if (present) begin
      if (own == 1) begin
        e_addr  = bus.dBus_cmd_payload_address;
        e_wdata = bus.dBus_cmd_payload_data;
        e_size  = 32'(bus.dBus_cmd_payload_size);
        e_wr    = bus.dBus_cmd_payload_wr;
      end else begin
        e_addr = bus.iBus_cmd_payload_pc;
        e_size = 32'd2;
      end
    end
    e_i = hit && !head;
    e_d = hit && head;
    chk("mem_cmd_valid", 32'(bus.mem_cmd_valid), 32'(present));
    chk("iBus_cmd_ready", 32'(bus.iBus_cmd_ready), 32'(acc && own == 0));
    chk("dBus_cmd_ready", 32'(bus.dBus_cmd_ready), 32'(acc && own == 1));
    chk("mem_cmd_addr", bus.mem_cmd_addr, e_addr);
    chk("mem_cmd_wdata", bus.mem_cmd_wdata, e_wdata);
    chk("mem_cmd_size", 32'(bus.mem_cmd_size), e_size);
    chk("mem_cmd_wr", 32'(bus.mem_cmd_wr), 32'(e_wr));
    chk("iBus_rsp_ready", 32'(bus.iBus_rsp_ready), 32'(e_i));
    chk("iBus_rsp_inst", bus.iBus_rsp_inst, e_i ? bus.mem_rsp_rdata : 32'd0);
    chk("iBus_rsp_err", 32'(bus.iBus_rsp_err), e_i ? 32'(bus.mem_rsp_err) : 32'd0);
    chk("dBus_rsp_ready", 32'(bus.dBus_rsp_ready), 32'(e_d));
    chk("dBus_rsp_data", bus.dBus_rsp_data, e_d ? bus.mem_rsp_rdata : 32'd0);
    chk("dBus_rsp_err", 32'(bus.dBus_rsp_err), e_d ? 32'(bus.mem_rsp_err) : 32'd0);
    chk("rsp_orphan", 32'(orphan), 32'(r ? 1'b0 : orphan_m));
    snap_grant  = bus.iBus_cmd_ready ? 0 : (bus.dBus_cmd_ready ? 1 : -1);
    snap_irsp   = bus.iBus_rsp_ready;
    snap_drsp   = bus.dBus_rsp_ready;
    snap_derr   = bus.dBus_rsp_err;
    snap_inst   = bus.iBus_rsp_inst;
    snap_mvalid = bus.mem_cmd_valid;
    snap_addr   = bus.mem_cmd_addr;
    snap_wdata  = bus.mem_cmd_wdata;
    snap_wr     = bus.mem_cmd_wr;
    snap_orphan = orphan;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (orph) orphan_m = 1'b1;
      if (hit) void'(idq.pop_front());
      if (acc) begin
        idq.push_back(bit'(own));
        last_m = own;
        lock_m = -1;
      end else if (present && lock_m < 0) begin
        lock_m = own;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit          pat [10];
    bit          pend_i, pend_d, rv;
    int          mem_out;
    logic [31:0] tmp;

    pat = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    model_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Round-robin conflict right after reset: I, D, I, D.
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h100;
    bus.dBus_cmd_valid = 1; bus.dBus_cmd_payload_address = 32'h2000; bus.dBus_cmd_payload_size = 2;
    bus.mem_cmd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rsp_valid = (k >= 1);
      bus.mem_rsp_rdata = 32'h1000 + 32'(k);
      step();
      chk("rr_grant", snap_grant, k % 2);
    end
    bus.iBus_cmd_valid = 0; bus.dBus_cmd_valid = 0;
    bus.mem_rsp_valid = 1;
    step();
    bus.mem_rsp_valid = 0;

    // Single fetch and its response.
    bus.iBus_cmd_valid = 1; bus.iBus_cmd_payload_pc = 32'h100;
    step();
    chk("fetch_grant", snap_grant, 0);
    chk("fetch_addr", snap_addr, 32'h100);
    bus.iBus_cmd_valid = 0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h00000013;
    step();
    chk("fetch_irsp", 32'(snap_irsp), 1);
    chk("fetch_inst", snap_inst, 32'h00000013);
    chk("fetch_drsp", 32'(snap_drsp), 0);
    bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0;

    // Lock: dBus write stalled 3 cycles while iBus raises valid.
    bus.dBus_cmd_valid = 1; bus.dBus_cmd_payload_address = 32'h2000;
    bus.dBus_cmd_payload_data = 32'hDEADBEEF; bus.dBus_cmd_payload_wr = 1;
    bus.mem_cmd_ready = 0;
    bus.iBus_cmd_payload_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      bus.iBus_cmd_valid = (k >= 1);
      step();
      chk("lock_addr", snap_addr, 32'h2000);
      chk("lock_wdata", snap_wdata, 32'hDEADBEEF);
      chk("lock_wr", 32'(snap_wr), 1);
    end
    bus.mem_cmd_ready = 1;
    step();
    chk("lock_accept_d", snap_grant, 1);
    bus.dBus_cmd_valid = 0; bus.dBus_cmd_payload_wr = 0;
    step();
    chk("lock_next_i", snap_grant, 0);
    bus.iBus_cmd_valid = 0;
    bus.mem_rsp_valid = 1;
    step();
    step();
    bus.mem_rsp_valid = 0;

    // Full FIFO: 4 accepted, 5th stalls; a pop does not unblock the same cycle.
    bus.iBus_cmd_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus.iBus_cmd_payload_pc = 32'h300 + 32'(4 * k);
      step();
      chk("full_fill", snap_grant, 0);
    end
    bus.iBus_cmd_payload_pc = 32'h310;
    step();
    chk("full_stall", snap_grant, -1);
    chk("full_mvalid", 32'(snap_mvalid), 0);
    bus.mem_rsp_valid = 1;
    step();
    chk("full_pop_stall", snap_grant, -1);
    chk("full_pop_irsp", 32'(snap_irsp), 1);
    bus.mem_rsp_valid = 0;
    step();
    chk("full_push_next", snap_grant, 0);
    bus.iBus_cmd_valid = 0;
    bus.mem_rsp_valid = 1;
    for (int k = 0; k < 4; k++) step();
    bus.mem_rsp_valid = 0;

    // Ordering across pointer wrap, responses lagging by two cycles.
    for (int c = 0; c < 12; c++) begin
      bus.iBus_cmd_valid = (c < 10) && !pat[c % 10];
      bus.dBus_cmd_valid = (c < 10) && pat[c % 10];
      bus.iBus_cmd_payload_pc = 32'h500 + 32'(4 * c);
      bus.dBus_cmd_payload_address = 32'h4000 + 32'(4 * c);
      bus.mem_rsp_valid = (c >= 2);
      bus.mem_rsp_rdata = 32'hA000 + 32'(c);
      bus.mem_rsp_err = (c == 4);
      step();
      if (c >= 2) begin
        chk("order_drsp", 32'(snap_drsp), 32'(pat[c - 2]));
        chk("order_irsp", 32'(snap_irsp), 32'(!pat[c - 2]));
      end
      if (c == 4) chk("order_derr", 32'(snap_derr), 1);
    end
    idle_inputs();

    // Randomized traffic with protocol-abiding requesters and an in-order memory.
    pend_i = 0; pend_d = 0; mem_out = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pend_i && $urandom_range(0, 2) == 0) begin
        pend_i = 1;
        tmp = $urandom();
        bus.iBus_cmd_payload_pc = tmp & 32'hFFFF_FFFC;
      end
      if (!pend_d && $urandom_range(0, 2) == 0) begin
        pend_d = 1;
        bus.dBus_cmd_payload_address = $urandom();
        bus.dBus_cmd_payload_data = $urandom();
        bus.dBus_cmd_payload_size = 2'($urandom_range(0, 2));
        bus.dBus_cmd_payload_wr = 1'($urandom_range(0, 1));
      end
      bus.iBus_cmd_valid = pend_i;
      bus.dBus_cmd_valid = pend_d;
      bus.mem_cmd_ready = ($urandom_range(0, 3) != 0);
      rv = (mem_out > 0) && ($urandom_range(0, 1) == 1);
      bus.mem_rsp_valid = rv;
      bus.mem_rsp_rdata = $urandom();
      bus.mem_rsp_err = ($urandom_range(0, 7) == 0);
      step();
      if (rv) mem_out--;
      if (snap_grant >= 0) mem_out++;
      if (snap_grant == 0) pend_i = 0;
      if (snap_grant == 1) pend_d = 0;
    end
    idle_inputs();
    for (int k = 0; k < DEPTH && mem_out > 0; k++) begin
      bus.mem_rsp_valid = 1;
      step();
      mem_out--;
    end
    bus.mem_rsp_valid = 0;
    chk("drain_done", 32'(mem_out), 0);

    // DBUS_PRIORITY=1: dBus wins every conflict, iBus starved.
    bus1.iBus_cmd_valid = 1; bus1.iBus_cmd_payload_pc = 32'h100;
    bus1.dBus_cmd_valid = 1; bus1.dBus_cmd_payload_address = 32'h2000;
    bus1.mem_cmd_ready = 1;
    for (int k = 0; k < 6; k++) begin
      bus1.mem_rsp_valid = (k >= 1);
      #1;
      chk("prio_dready", 32'(bus1.dBus_cmd_ready), 1);
      chk("prio_iready", 32'(bus1.iBus_cmd_ready), 0);
      chk("prio_addr", bus1.mem_cmd_addr, 32'h2000);
      if (k >= 1) chk("prio_drsp", 32'(bus1.dBus_rsp_ready), 1);
      @(negedge clk);
    end
    idle_inputs();

    // Reset with two outstanding: later response is an orphan, sticky until reset.
    bus.iBus_cmd_valid = 1; bus.mem_cmd_ready = 1;
    bus.iBus_cmd_payload_pc = 32'h600;
    step();
    bus.iBus_cmd_payload_pc = 32'h604;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'h77;
    step();
    chk("orphan_irsp", 32'(snap_irsp), 0);
    chk("orphan_drsp", 32'(snap_drsp), 0);
    bus.mem_rsp_valid = 0;
    step();
    chk("orphan_set", 32'(snap_orphan), 1);
    step();
    chk("orphan_sticky", 32'(snap_orphan), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one memory port between the core's instruction bus (iBus) and data bus (dBus). It arbitrates commands, locks the winner until the memory accepts, and records the source of every accepted command in an in-order ID FIFO. Each memory response is steered back to the requester that issued it. It sits between the `riscv` core and the single-ported memory/interconnect.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 4: ID FIFO depth, i.e. maximum accepted-but-unanswered commands; power of 2, ≥2.
- `DBUS_PRIORITY`, 0: 1 = dBus always wins a conflict; 0 = round-robin.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `iBus_cmd_valid` in 1, `iBus_cmd_ready` out 1, `iBus_cmd_payload_pc` in 32: instruction fetch command (word-aligned byte address).
- `iBus_rsp_ready` out 1, `iBus_rsp_err` out 1, `iBus_rsp_inst` out 32: instruction response; `iBus_rsp_ready` is a one-cycle valid strobe.
- `dBus_cmd_valid` in 1, `dBus_cmd_ready` out 1: data command handshake.
- `dBus_cmd_payload_address` in 32, `dBus_cmd_payload_data` in 32, `dBus_cmd_payload_size` in 2, `dBus_cmd_payload_wr` in 1: data command payload (size 0/1/2 = byte/half/word).
- `dBus_rsp_ready` out 1, `dBus_rsp_err` out 1, `dBus_rsp_data` out 32: data response strobe; also issued for writes (ack).
- `mem_cmd_valid` out 1, `mem_cmd_ready` in 1, `mem_cmd_addr` out 32, `mem_cmd_wdata` out 32, `mem_cmd_size` out 2, `mem_cmd_wr` out 1: shared memory command.
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in 32, `mem_rsp_err` in 1: memory response; exactly one per accepted command, in order.
- `rsp_orphan` out 1: sticky; set when a response arrives with the ID FIFO empty.

## Operation
- Command FSM states:
  - IDLE: no lock.
  - HOLD_I: iBus owns the port.
  - HOLD_D: dBus owns the port.
- Owner selection:
  - In HOLD_x, the owner is x.
  - In IDLE, the owner is the single requester with valid asserted.
  - On a conflict in IDLE, dBus wins if `DBUS_PRIORITY`=1. Otherwise the requester other than `last_grant` wins.
- Blocked condition: `blocked = fifo_full`. While blocked, `mem_cmd_valid`=0 and both cmd_ready=0. A same-cycle response pop does not unblock that cycle.
- Command path (when not blocked and the owner's valid=1):
  - `mem_cmd_valid`=1, and `mem_cmd_*` mirror the owner's payload.
  - iBus commands drive `size`=2, `wr`=0, `wdata`=0.
  - When idle, all `mem_cmd_*` are driven 0.
- Acceptance: `owner_cmd_ready = mem_cmd_ready & ~blocked`; the non-owner's ready=0. On accept:
  - push owner ID (0=I, 1=D);
  - update `last_grant`;
  - FSM→IDLE.
- Lock: if presented but not accepted in IDLE, FSM→HOLD_owner. The lock is held until accept. Requesters must hold valid/payload stable; arbitration does not change while locked.
- Response path:
  - When `mem_rsp_valid`=1 and the FIFO is non-empty, pop the head ID.
  - Pulse that requester's rsp strobe for the same cycle, with `rdata`→inst/data and `err`→err.
  - The other requester's strobe stays 0.
  - No backpressure toward memory.
- Orphan response (FIFO empty): discard it and set `rsp_orphan`. It is cleared only by reset.
- FIFO:
  - Circular buffer with `$clog2(MAX_OUTSTANDING)`-bit pointers that wrap modulo depth.
  - Count 0..`MAX_OUTSTANDING`.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.

## Timing
- Command path is combinational: zero-cycle latency requester→`mem_cmd`; `mem_cmd_ready`→requester ready is same-cycle.
- Response steering is combinational (zero latency). Steering uses the FIFO head registered state.
- FIFO/FSM/`last_grant` update on the `clk` rising edge.
- Reset (asynchronous, immediate):
  - FSM=IDLE, FIFO empty, `last_grant`=D (iBus wins the first round-robin conflict), `rsp_orphan`=0.
  - All valid/ready/strobe outputs 0; all data outputs 0.
- Reset mid-transaction: outstanding IDs are lost. Responses arriving after reset are orphans.
- Maximum throughput: one accepted command per cycle, and one response per cycle concurrently.

## Test plan
- Single fetch: `iBus_cmd_valid`=1, pc=0x100, `mem_cmd_ready`=1 → same cycle `mem_cmd_addr`=0x100, `size`=2, `wr`=0. Then response rdata=0x00000013 → `iBus_rsp_ready` pulse with inst=0x00000013; `dBus_rsp_ready`=0.
- Round-robin conflict (`DBUS_PRIORITY`=0): both valid every cycle, `mem_cmd_ready`=1 → grants alternate I, D, I, D starting with I after reset. With `DBUS_PRIORITY`=1 → D every cycle; iBus starved.
- Lock: dBus write (addr 0x2000, data 0xDEADBEEF, `wr`=1) with `mem_cmd_ready`=0 for 3 cycles while iBus raises valid → payload stable and owner D throughout; accept on cycle 4; iBus is granted the next cycle.
- Full: `MAX_OUTSTANDING`=4, accept 4 commands with no responses → 5th stalls (cmd_ready=0, `mem_cmd_valid`=0). A response plus a pending command in the same cycle → no push that cycle; push occurs the following cycle.
- Ordering/wrap: interleave I,D,D,I,… for 10 commands with responses lagging 2 cycles → each response reaches the correct source in order across pointer wrap. A response with err=1 on a D slot → `dBus_rsp_err`=1 only.
- Orphan/reset: assert `rst` with 2 outstanding, release, then drive `mem_rsp_valid` → no rsp strobes, `rsp_orphan`=1 and stays 1.
